// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: FSM encodings, scoreboard depth
// and the scoreboard entry layout.
package hazard_unit_pkg;

    localparam int SB_DEPTH_FIXED = 3;
    // EX and MEM1 are the only stages whose load data cannot yet be forwarded.
    localparam int FWD_WINDOW = 2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    // Register x0 is hard-wired to zero, so it can never create a dependency.
    function automatic logic reg_match(input sb_entry_t entry, input logic [4:0] rs,
                                       input logic used);
        return entry.valid && used && (rs != 5'd0) && (entry.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker (EX, MEM1, MEM2) with decode-operand match logic.
// HAZARD_FORWARDING_EN narrows hazards to loads still in EX or MEM1.
module hazard_scoreboard
    import hazard_unit_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_FIXED
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic       issue_load,
    input  logic [4:0] id_rs1,
    input  logic       id_rs1_used,
    input  logic [4:0] id_rs2,
    input  logic       id_rs2_used,
    output logic       hazard
);

    sb_entry_t entries [DEPTH];

    // A write to x0 is recorded as a bubble so it can never be matched later.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (advance) begin
            if (issue_valid && (issue_rd != 5'd0)) begin
                entries[0] <= '{valid: 1'b1, rd: issue_rd, is_load: issue_load};
            end else begin
                entries[0] <= '0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (reg_match(entries[i], id_rs1, id_rs1_used) ||
                reg_match(entries[i], id_rs2, id_rs2_used)) begin
`ifdef HAZARD_FORWARDING_EN
                if ((i < FWD_WINDOW) && entries[i].is_load) begin
                    hazard = 1'b1;
                end
`else
                hazard = 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: memory-wait / redirect FSM plus scoreboard-driven
// decode stalls. Build option: HAZARD_FORWARDING_EN (load-only hazards in EX/MEM1).
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CORE     = 0,
    parameter int SB_DEPTH = SB_DEPTH_FIXED
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       id_regWrite,
    input  logic       id_memRead,
    input  logic       ex_redirect,
    input  logic       imem_busy,
    input  logic       dmem_busy,
    output logic       stall_front,
    output logic       bubble_ex,
    output logic       flush_front,
    output logic       freeze_all,
    output logic [1:0] state_o
);

    if (SB_DEPTH != SB_DEPTH_FIXED || CORE < 0) begin : g_bad_config
        $error("hazard_unit core %0d: SB_DEPTH must be %0d", CORE, SB_DEPTH_FIXED);
    end

    hazard_state_e state;
    logic          pending_redirect;
    logic          data_hazard;
    logic          redirect_now;
    logic          issue_valid;
    logic          sb_advance;

    hazard_scoreboard #(
        .DEPTH(SB_DEPTH)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .advance    (sb_advance),
        .issue_valid(issue_valid),
        .issue_rd   (id_rd),
        .issue_load (id_memRead),
        .id_rs1     (id_rs1),
        .id_rs1_used(id_rs1_used),
        .id_rs2     (id_rs2),
        .id_rs2_used(id_rs2_used),
        .hazard     (data_hazard)
    );

    // A redirect deferred through MEM_WAIT is not flushed on release; the FLUSH
    // state that follows provides its single squash cycle.
    assign redirect_now = (state == ST_FLUSH) || ex_redirect;

    always_comb begin
        stall_front = 1'b0;
        bubble_ex   = 1'b0;
        flush_front = 1'b0;
        freeze_all  = 1'b0;
        if (!reset) begin
            if (dmem_busy) begin
                freeze_all = 1'b1;
            end else if (redirect_now) begin
                flush_front = 1'b1;
                bubble_ex   = 1'b1;
            end else if (id_valid && data_hazard) begin
                stall_front = 1'b1;
                bubble_ex   = 1'b1;
            end else if (imem_busy) begin
                stall_front = 1'b1;
                bubble_ex   = 1'b1;
            end
        end
    end

    assign issue_valid = id_valid && id_regWrite && !stall_front && !flush_front;
    assign sb_advance  = !freeze_all;
    assign state_o     = reset ? ST_RUN : state;

    // A redirect seen while the data cache is busy is remembered until release.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_RUN;
            pending_redirect <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dmem_busy) begin
                        state <= ST_MEM_WAIT;
                        if (ex_redirect) begin
                            pending_redirect <= 1'b1;
                        end
                    end else if (ex_redirect) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_busy) begin
                        if (ex_redirect) begin
                            pending_redirect <= 1'b1;
                        end
                    end else if (pending_redirect || ex_redirect) begin
                        state            <= ST_FLUSH;
                        pending_redirect <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_RUN;
                end
                default: begin
                    state            <= ST_RUN;
                    pending_redirect <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; expectations are queued when each
// step is driven and popped when the outputs are sampled on the falling edge.
module tb_hazard_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_regWrite, id_memRead;
    logic       ex_redirect, imem_busy, dmem_busy;
    logic       stall_front, bubble_ex, flush_front, freeze_all;
    logic [1:0] state_o;

`ifdef HAZARD_FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif
    localparam logic NF = !FWD;

    typedef struct {
        string      tag;
        logic       stall;
        logic       bubble;
        logic       flush;
        logic       freeze;
        logic [1:0] st;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    hazard_unit #(.CORE(0), .SB_DEPTH(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_regWrite(id_regWrite),
        .id_memRead (id_memRead),
        .ex_redirect(ex_redirect),
        .imem_busy  (imem_busy),
        .dmem_busy  (dmem_busy),
        .stall_front(stall_front),
        .bubble_ex  (bubble_ex),
        .flush_front(flush_front),
        .freeze_all (freeze_all),
        .state_o    (state_o)
    );

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic redir,
                                 input logic ibusy, input logic dbusy);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_regWrite = rw;
        id_memRead  = mr;
        ex_redirect = redir;
        imem_busy   = ibusy;
        dmem_busy   = dbusy;
    endtask

    task automatic idle(input logic redir, input logic dbusy);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, redir, 1'b0, dbusy);
    endtask

    task automatic cmp(input string tag, input string field, input logic [1:0] obs,
                       input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clock);
        e = expq.pop_front();
        cmp(e.tag, "stall_front", {1'b0, stall_front}, {1'b0, e.stall});
        cmp(e.tag, "bubble_ex",   {1'b0, bubble_ex},   {1'b0, e.bubble});
        cmp(e.tag, "flush_front", {1'b0, flush_front}, {1'b0, e.flush});
        cmp(e.tag, "freeze_all",  {1'b0, freeze_all},  {1'b0, e.freeze});
        cmp(e.tag, "state_o",     state_o,             e.st);
    endtask

    // Queue the expectation for the inputs just driven, check it, then advance one cycle.
    task automatic step(input string tag, input logic s, input logic b, input logic f,
                        input logic z, input logic [1:0] st);
        exp_t e;
        e.tag = tag; e.stall = s; e.bubble = b; e.flush = f; e.freeze = z; e.st = st;
        expq.push_back(e);
        checkOutput();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("reset0", 0, 0, 0, 0, 2'd0);
        step("reset1", 0, 0, 0, 0, 2'd0);
        reset = 1'b0;
        idle(1'b0, 1'b0);
        step("idle", 0, 0, 0, 0, 2'd0);

        // Load x5 followed by a dependent add.
        applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0);
        step("ld5_issue", 0, 0, 0, 0, 2'd0);
        applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0);
        step("ld5_use_ex", 1, 1, 0, 0, 2'd0);
        step("ld5_use_mem1", 1, 1, 0, 0, 2'd0);
        step("ld5_use_mem2", NF, NF, 0, 0, 2'd0);
        step("ld5_use_done", 0, 0, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0);
            step("drain1", 0, 0, 0, 0, 2'd0);
        end

        // ALU write to x5 observed from EX, MEM1 (unused operand) and MEM2.
        applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0);
        step("alu5_issue", 0, 0, 0, 0, 2'd0);
        applyStimulus(1, 5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 0, 0, 0);
        step("alu5_ex_rs2", NF, NF, 0, 0, 2'd0);
        applyStimulus(1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
        step("alu5_rs1_unused", 0, 0, 0, 0, 2'd0);
        applyStimulus(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
        step("alu5_mem2", NF, NF, 0, 0, 2'd0);
        step("alu5_gone", 0, 0, 0, 0, 2'd0);

        // Load to x0 never creates a dependency on x0.
        applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0);
        step("x0_issue", 0, 0, 0, 0, 2'd0);
        applyStimulus(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0);
        step("x0_use", 0, 0, 0, 0, 2'd0);

        applyStimulus(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
        step("imem_busy", 1, 1, 0, 0, 2'd0);

        // Four-cycle data miss with a redirect arriving mid-miss.
        idle(1'b0, 1'b1);
        step("dbusy_c0", 0, 0, 0, 1, 2'd0);
        step("dbusy_c1", 0, 0, 0, 1, 2'd1);
        idle(1'b1, 1'b1);
        step("dbusy_c2_redir", 0, 0, 0, 1, 2'd1);
        idle(1'b0, 1'b1);
        step("dbusy_c3", 0, 0, 0, 1, 2'd1);
        idle(1'b0, 1'b0);
        step("dbusy_release", 0, 0, 0, 0, 2'd1);
        step("pending_flush", 0, 1, 1, 0, 2'd2);
        step("back_to_run", 0, 0, 0, 0, 2'd0);

        // Scoreboard must hold a load in EX across a freeze.
        applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0);
        step("ld7_issue", 0, 0, 0, 0, 2'd0);
        applyStimulus(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 1);
        step("ld7_frozen", 0, 0, 0, 1, 2'd0);
        applyStimulus(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0);
        step("ld7_held_ex", 1, 1, 0, 0, 2'd1);
        step("ld7_mem1", 1, 1, 0, 0, 2'd0);
        step("ld7_mem2", NF, NF, 0, 0, 2'd0);
        step("ld7_done", 0, 0, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0);
            step("drain2", 0, 0, 0, 0, 2'd0);
        end

        // Redirect wins over a simultaneous load-use hazard.
        applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0, 0, 0);
        step("ld8_issue", 0, 0, 0, 0, 2'd0);
        applyStimulus(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 1, 0, 0);
        step("redir_vs_loaduse", 0, 1, 1, 0, 2'd0);
        idle(1'b0, 1'b0);
        step("redir_flush", 0, 1, 1, 0, 2'd2);
        step("redir_done", 0, 0, 0, 0, 2'd0);

        // Reset during FLUSH clears state and the scoreboard.
        applyStimulus(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0, 0, 0);
        step("ld9_issue", 0, 0, 0, 0, 2'd0);
        idle(1'b1, 1'b0);
        step("redir_idle", 0, 1, 1, 0, 2'd0);
        reset = 1'b1;
        applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
        step("rst_in_flush", 0, 0, 0, 0, 2'd0);
        reset = 1'b0;
        step("post_rst_use", 0, 0, 0, 0, 2'd0);
        idle(1'b0, 1'b0);
        step("post_rst_idle", 0, 0, 0, 0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
